// File: rtl/clock_disp_pkg.sv
// Shared constants for the HH:MM:SS seven-segment display path.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [2:0] DIG_SS_U = 3'd0;
    localparam logic [2:0] DIG_SS_T = 3'd1;
    localparam logic [2:0] DIG_MM_U = 3'd2;
    localparam logic [2:0] DIG_MM_T = 3'd3;
    localparam logic [2:0] DIG_HH_U = 3'd4;
    localparam logic [2:0] DIG_HH_T = 3'd5;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [5:0] AN_OFF   = 6'h3F;

    // One-cold anode pattern for a digit index.
    function automatic logic [5:0] an_select(input logic [2:0] idx);
        return ~(6'b000001 << idx);
    endfunction

endpackage

// File: rtl/clock_disp_mux_bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Non-decimal nibbles render as a dash.
module bcd_to_seg7
    import clock_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_disp_mux.sv
// Six-digit multiplexed display driver: per-frame input snapshot, per-slot
// guard/drive phases, registered active-low anode/segment/dp outputs.
module clock_disp_mux
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int BLANK_LZ  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [7:0] i_hh,
    input  logic [7:0] i_mm,
    input  logic [7:0] i_ss,
    input  logic       i_pm,
    input  logic [1:0] i_dpnt,
    output logic [5:0] o_an,
    output logic [6:0] o_seg,
    output logic       o_dp
);

    localparam int             CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  GUARD_END = CW'(BLANK_CYC);
    localparam logic [2:0]     IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sh_hh;
    logic [7:0]    sh_mm;
    logic [7:0]    sh_ss;
    logic          sh_pm;
    logic [1:0]    sh_dpnt;

    logic [3:0]    nib;
    logic [6:0]    dec_seg;
    logic          guard;
    logic          lz_blank;
    logic          dp_lit;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt     <= '0;
            idx     <= '0;
            sh_hh   <= '0;
            sh_mm   <= '0;
            sh_ss   <= '0;
            sh_pm   <= 1'b0;
            sh_dpnt <= '0;
        end else if (i_en) begin
            // A frame starts at slot 0, count 0: take one coherent sample.
            if (cnt == '0 && idx == DIG_SS_U) begin
                sh_hh   <= i_hh;
                sh_mm   <= i_mm;
                sh_ss   <= i_ss;
                sh_pm   <= i_pm;
                sh_dpnt <= i_dpnt;
            end
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        nib = 4'd0;
        case (idx)
            DIG_SS_U: nib = sh_ss[3:0];
            DIG_SS_T: nib = sh_ss[7:4];
            DIG_MM_U: nib = sh_mm[3:0];
            DIG_MM_T: nib = sh_mm[7:4];
            DIG_HH_U: nib = sh_hh[3:0];
            DIG_HH_T: nib = sh_hh[7:4];
            default:  nib = 4'd0;
        endcase
    end

    bcd_to_seg7 u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    assign guard    = (cnt < GUARD_END);
    assign lz_blank = (BLANK_LZ != 0) && (idx == DIG_HH_T) && (sh_hh[7:4] == 4'd0);
    assign dp_lit   = ((idx == DIG_SS_U) && sh_pm)
                    | ((idx == DIG_MM_U) && sh_dpnt[0])
                    | ((idx == DIG_HH_U) && sh_dpnt[1]);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_an  <= AN_OFF;
            o_seg <= SEG_OFF;
            o_dp  <= 1'b1;
        end else if (!i_en || guard) begin
            o_an  <= AN_OFF;
            o_seg <= SEG_OFF;
            o_dp  <= 1'b1;
        end else begin
            o_an  <= lz_blank ? AN_OFF  : an_select(idx);
            o_seg <= lz_blank ? SEG_OFF : dec_seg;
            o_dp  <= ~dp_lit;
        end
    end

endmodule

// File: tb/tb_clock_disp_mux.sv
// Bench for clock_disp_mux: directed scenarios plus randomized traffic against
// a frame-position reference model, on leading-zero-blank and non-blank builds.
module tb_clock_disp_mux;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 6 * SD;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] hh = 8'h00, mm = 8'h00, ss = 8'h00;
    logic       pm = 1'b0;
    logic [1:0] dpnt = 2'b00;

    logic [5:0] an1, an0;
    logic [6:0] seg1, seg0;
    logic       dp1, dp0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clock_disp_mux #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLANK_LZ(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_hh(hh), .i_mm(mm), .i_ss(ss),
        .i_pm(pm), .i_dpnt(dpnt), .o_an(an1), .o_seg(seg1), .o_dp(dp1)
    );

    clock_disp_mux #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLANK_LZ(0)) dut_nlz (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_hh(hh), .i_mm(mm), .i_ss(ss),
        .i_pm(pm), .i_dpnt(dpnt), .o_an(an0), .o_seg(seg0), .o_dp(dp0)
    );

    // Reference model: a single position within the frame (0..FRAME-1).
    int         m_pos;
    logic [7:0] m_hh, m_mm, m_ss;
    logic       m_pm;
    logic [1:0] m_dpnt;
    logic [5:0] e_an1, e_an0;
    logic [6:0] e_seg1, e_seg0;
    logic       e_dp;

    function automatic logic [3:0] nib_at(input int slot, input logic [7:0] h, input logic [7:0] m,
                                          input logic [7:0] s);
        logic [7:0] w;
        w = (slot < 2) ? s : (slot < 4) ? m : h;
        return (slot % 2 == 1) ? w[7:4] : w[3:0];
    endfunction

    function automatic logic dp_at(input int slot, input logic p, input logic [1:0] d);
        return !((slot == 0 && p) || (slot == 2 && d[0]) || (slot == 4 && d[1]));
    endfunction

    function automatic logic [5:0] an_at(input int slot);
        return 6'h3F ^ (6'd1 << slot);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pos <= 0;
            m_hh <= 8'h00; m_mm <= 8'h00; m_ss <= 8'h00; m_pm <= 1'b0; m_dpnt <= 2'b00;
            e_an1 <= 6'h3F; e_an0 <= 6'h3F; e_seg1 <= 7'h7F; e_seg0 <= 7'h7F; e_dp <= 1'b1;
        end else if (!en) begin
            e_an1 <= 6'h3F; e_an0 <= 6'h3F; e_seg1 <= 7'h7F; e_seg0 <= 7'h7F; e_dp <= 1'b1;
        end else begin
            if (m_pos % SD < BC) begin
                e_an1 <= 6'h3F; e_an0 <= 6'h3F; e_seg1 <= 7'h7F; e_seg0 <= 7'h7F; e_dp <= 1'b1;
            end else begin
                e_an0  <= an_at(m_pos / SD);
                e_seg0 <= SEG_TAB[nib_at(m_pos / SD, m_hh, m_mm, m_ss)];
                e_dp   <= dp_at(m_pos / SD, m_pm, m_dpnt);
                if (m_pos / SD == 5 && m_hh[7:4] == 4'd0) begin
                    e_an1  <= 6'h3F;
                    e_seg1 <= 7'h7F;
                end else begin
                    e_an1  <= an_at(m_pos / SD);
                    e_seg1 <= SEG_TAB[nib_at(m_pos / SD, m_hh, m_mm, m_ss)];
                end
            end
            if (m_pos == 0) begin
                m_hh <= hh; m_mm <= mm; m_ss <= ss; m_pm <= pm; m_dpnt <= dpnt;
            end
            m_pos <= (m_pos + 1) % FRAME;
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        #3 rst = 1'b0;
        #2;
        n_cmp++;
        if ({an1, seg1, dp1, an0, seg0, dp0} !== {6'h3F, 7'h7F, 1'b1, 6'h3F, 7'h7F, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_async: got an=%h seg=%h dp=%b, want an=3f seg=7f dp=1", an1, seg1, dp1);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({an1, seg1, dp1} !== {6'h3F, 7'h7F, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_hold: got an=%h seg=%h dp=%b, want an=3f seg=7f dp=1", an1, seg1, dp1);
        end
        hh = 8'h12; mm = 8'h34; ss = 8'h56; pm = 1'b0; dpnt = 2'b00; en = 1'b1;
        rst = 1'b1;
    endtask

    task automatic test_scan;
        for (int k = 1; k <= FRAME; k++) begin
            int p, s, c;
            logic [5:0] xa;
            logic [6:0] xs;
            @(negedge clk);
            p = k - 1; s = p / SD; c = p % SD;
            xa = (c < BC) ? 6'h3F : an_at(s);
            xs = (c < BC) ? 7'h7F : SEG_TAB[6 - s];
            n_cmp++;
            if ({an1, seg1, dp1} !== {xa, xs, 1'b1}) begin
                n_bad++;
                $display("FAIL scan_k%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=1", k, an1, seg1, dp1, xa, xs);
            end
            n_cmp++;
            if ({an1, seg1, dp1, an0, seg0, dp0} !== {e_an1, e_seg1, e_dp, e_an0, e_seg0, e_dp}) begin
                n_bad++;
                $display("FAIL scan_model_k%0d: got an=%h seg=%h, want an=%h seg=%h", k, an1, seg1, e_an1, e_seg1);
            end
        end
    endtask

    task automatic test_snapshot;
        for (int n = 0; n < 200 && m_pos != 2; n++) @(negedge clk);
        n_cmp++;
        if (m_pos != 2) begin n_bad++; $display("FAIL snap_wait: got pos=%0d, want pos=2", m_pos); end
        ss = 8'h57;
        @(negedge clk);
        n_cmp++;
        if ({an1, seg1} !== {6'h3E, SEG_TAB[6]}) begin
            n_bad++;
            $display("FAIL snap_same_frame: got an=%h seg=%h, want an=3e seg=%h", an1, seg1, SEG_TAB[6]);
        end
        repeat (FRAME) @(negedge clk);
        n_cmp++;
        if ({an1, seg1} !== {6'h3E, SEG_TAB[7]}) begin
            n_bad++;
            $display("FAIL snap_next_frame: got an=%h seg=%h, want an=3e seg=%h", an1, seg1, SEG_TAB[7]);
        end
    endtask

    task automatic test_leading_zero;
        hh = 8'h09;
        repeat (FRAME) @(negedge clk);
        for (int n = 0; n < 200 && m_pos != 5 * SD + 3; n++) @(negedge clk);
        n_cmp++;
        if ({an1, seg1} !== {6'h3F, 7'h7F}) begin
            n_bad++;
            $display("FAIL lz_blank: got an=%h seg=%h, want an=3f seg=7f", an1, seg1);
        end
        n_cmp++;
        if ({an0, seg0} !== {6'h1F, 7'h40}) begin
            n_bad++;
            $display("FAIL lz_off_zero: got an=%h seg=%h, want an=1f seg=40", an0, seg0);
        end
        hh = 8'h12;
    endtask

    task automatic test_dp;
        pm = 1'b1; dpnt = 2'b01;
        repeat (FRAME) @(negedge clk);
        for (int k = 0; k < FRAME; k++) begin
            int p, s;
            logic xd;
            @(negedge clk);
            p = (m_pos + FRAME - 1) % FRAME; s = p / SD;
            xd = (p % SD < BC) ? 1'b1 : !(s == 0 || s == 2);
            n_cmp++;
            if (dp1 !== xd) begin n_bad++; $display("FAIL dp_pm_mmss_pos%0d: got dp=%b, want dp=%b", p, dp1, xd); end
        end
        pm = 1'b0; dpnt = 2'b10;
        repeat (FRAME) @(negedge clk);
        for (int k = 0; k < FRAME; k++) begin
            int p, s;
            logic xd;
            @(negedge clk);
            p = (m_pos + FRAME - 1) % FRAME; s = p / SD;
            xd = (p % SD < BC) ? 1'b1 : !(s == 4);
            n_cmp++;
            if (dp1 !== xd) begin n_bad++; $display("FAIL dp_hhmm_pos%0d: got dp=%b, want dp=%b", p, dp1, xd); end
        end
        dpnt = 2'b00;
    endtask

    task automatic test_dash;
        ss = 8'h5C;
        repeat (FRAME) @(negedge clk);
        for (int n = 0; n < 200 && m_pos != 3; n++) @(negedge clk);
        n_cmp++;
        if ({an1, seg1} !== {6'h3E, 7'b0111111}) begin
            n_bad++;
            $display("FAIL dash: got an=%h seg=%h, want an=3e seg=3f", an1, seg1);
        end
        ss = 8'h56;
    endtask

    task automatic test_enable;
        for (int n = 0; n < 200 && m_pos != 20; n++) @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({an1, seg1, dp1} !== {6'h3F, 7'h7F, 1'b1}) begin
                n_bad++;
                $display("FAIL en_low_blank_c%0d: got an=%h seg=%h dp=%b, want an=3f seg=7f dp=1", k, an1, seg1, dp1);
            end
        end
        en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (an1 !== 6'h3B) begin n_bad++; $display("FAIL en_resume_slot: got an=%h, want an=3b", an1); end
        // Drop enable exactly on the wrap count: slot must not advance.
        for (int n = 0; n < 200 && m_pos != SD - 1; n++) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (an1 !== 6'h3E) begin n_bad++; $display("FAIL en_wrap_hold: got an=%h, want an=3e", an1); end
        @(negedge clk);
        n_cmp++;
        if (an1 !== 6'h3F) begin n_bad++; $display("FAIL en_wrap_guard: got an=%h, want an=3f", an1); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (an1 !== 6'h3D) begin n_bad++; $display("FAIL en_wrap_next: got an=%h, want an=3d", an1); end
    endtask

    task automatic test_reset_mid;
        for (int n = 0; n < 200 && m_pos != 30; n++) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({an1, seg1, dp1, an0, seg0, dp0} !== {6'h3F, 7'h7F, 1'b1, 6'h3F, 7'h7F, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_mid: got an=%h seg=%h dp=%b, want an=3f seg=7f dp=1", an1, seg1, dp1);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= BC + 1; k++) @(negedge clk);
        n_cmp++;
        if ({an1, seg1} !== {6'h3E, SEG_TAB[ss[3:0]]}) begin
            n_bad++;
            $display("FAIL reset_restart: got an=%h seg=%h, want an=3e seg=%h", an1, seg1, SEG_TAB[ss[3:0]]);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 900; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({an1, seg1, dp1, an0, seg0, dp0} !== {e_an1, e_seg1, e_dp, e_an0, e_seg0, e_dp}) begin
                n_bad++;
                $display("FAIL random_c%0d: got an=%h/%h seg=%h/%h dp=%b/%b, want an=%h/%h seg=%h/%h dp=%b",
                         k, an1, an0, seg1, seg0, dp1, dp0, e_an1, e_an0, e_seg1, e_seg0, e_dp);
            end
            hh   = ($urandom_range(0, 3) == 0) ? {4'h0, 4'($urandom)} : 8'($urandom);
            mm   = 8'($urandom);
            ss   = 8'($urandom);
            pm   = 1'($urandom);
            dpnt = 2'($urandom);
            en   = ($urandom_range(0, 9) != 0);
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset;
        test_scan;
        test_snapshot;
        test_leading_zero;
        test_dp;
        test_dash;
        test_enable;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
